// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcode map and immediate format encoding shared by the immediate generator
package imm_gen_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_R32    = 7'b0111011;
  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational opcode decode to sign-extended immediate, format tag and illegal flag
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);
  logic [6:0] op;
  logic s;
  logic signed [31:0] v;
  fmt_e f;
  assign op = instr[6:0];
  assign s = instr[31];
  // Every format fits in 32 signed bits; widening to XLEN is a plain sign-extension.
  always_comb begin
    f = FMT_NONE;
    v = '0;
    illegal = 1'b0;
    case (op)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: begin
        f = FMT_I;
        v = {{20{s}}, instr[31:20]};
      end
      OP_STORE: begin
        f = FMT_S;
        v = {{20{s}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        f = FMT_B;
        v = {{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        f = FMT_U;
        v = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        f = FMT_J;
        v = {{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_R, OP_R32: ;
      default: illegal = 1'b1;
    endcase
  end
  assign imm = XLEN'(v);
  assign fmt = f;
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with valid/ready handshake and 2-entry skid buffer
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  logic [XLEN-1:0] d_imm, main_imm, skid_imm;
  logic [2:0] d_fmt, main_fmt, skid_fmt;
  logic d_ill, main_ill, skid_ill;
  logic main_v, skid_v, acc;
  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr(in_instr),
    .imm(d_imm),
    .fmt(d_fmt),
    .illegal(d_ill)
  );
  // in_ready depends only on skid occupancy, so there is no comb path from out_ready.
  assign in_ready = !skid_v;
  assign acc = in_valid && in_ready && !flush;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      main_v <= 1'b0;
      main_imm <= '0;
      main_fmt <= '0;
      main_ill <= 1'b0;
      skid_v <= 1'b0;
      skid_imm <= '0;
      skid_fmt <= '0;
      skid_ill <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      main_v <= skid_v || acc;
      if (skid_v) begin
        main_imm <= skid_imm;
        main_fmt <= skid_fmt;
        main_ill <= skid_ill;
        skid_v <= 1'b0;
      end else if (acc) begin
        main_imm <= d_imm;
        main_fmt <= d_fmt;
        main_ill <= d_ill;
      end
    end else if (acc) begin
      skid_v <= 1'b1;
      skid_imm <= d_imm;
      skid_fmt <= d_fmt;
      skid_ill <= d_ill;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) illegal_cnt <= '0;
    else if (acc && d_ill && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
  assign out_valid = main_v;
  assign out_imm = main_imm;
  assign out_fmt = main_fmt;
  assign out_illegal = main_ill;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe at XLEN=64/CNT_W=2 with a shadow XLEN=32 instance
module tb_imm_gen_pipe;
  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_instr = '0;
  logic in_ready, out_valid, out_illegal, in_ready32, out_valid32, out_illegal32;
  logic [63:0] out_imm;
  logic [31:0] out_imm32;
  logic [2:0] out_fmt, out_fmt32;
  logic [1:0] illegal_cnt;
  logic [15:0] illegal_cnt32;
  int n_tests = 0, n_fail = 0, n_pop = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );
  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_illegal32), .illegal_cnt(illegal_cnt32)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [31:0] i);
    logic [63:0] sm;
    exp_t e;
    sm = {64{i[31]}};
    e = '0;
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: e = '{(sm << 12) | 64'(i[31:20]), 3'd1, 1'b0};
      7'h23: e = '{(sm << 12) | (64'(i[31:25]) << 5) | 64'(i[11:7]), 3'd2, 1'b0};
      7'h63: e = '{(sm << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1), 3'd3, 1'b0};
      7'h37, 7'h17: e = '{(sm << 32) | (64'(i[31:12]) << 12), 3'd4, 1'b0};
      7'h6F: e = '{(sm << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1), 3'd5, 1'b0};
      7'h33, 7'h3B: e = '{64'd0, 3'd0, 1'b0};
      default: e = '{64'd0, 3'd0, 1'b1};
    endcase
    return e;
  endfunction
  // Scoreboard: a transfer happens at the coming edge whenever out_valid && out_ready.
  always begin
    @(negedge clk);
    #1;
    if (!reset && !flush && out_valid && out_ready) begin
      if (q.size() == 0) check("sb_extra", 64'(out_imm), 64'hDEAD);
      else begin
        exp_t e;
        e = q.pop_front();
        n_pop++;
        check("sb_imm", out_imm, e.imm);
        check("sb_fmt", 64'(out_fmt), 64'(e.fmt));
        check("sb_ill", 64'(out_illegal), 64'(e.ill));
        check("sb_imm32", 64'(out_imm32), 64'(e.imm[31:0]));
        check("sb_v32", 64'(out_valid32), 64'd1);
      end
    end
  end
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] instr, output int waits);
    bit done = 0;
    waits = 0;
    in_valid = 1;
    in_instr = instr;
    while (!done && waits < 20) begin
      if (in_ready) begin
        q.push_back(model(instr));
        done = 1;
      end else waits++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 0;
    if (!done) check("send_timeout", 64'(waits), 64'd0);
  endtask
  task automatic drain();
    int k = 0;
    out_ready = 1;
    while (q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask
  initial begin
    int w, p0;
    logic [31:0] ops [12];
    ops = '{32'h03, 32'h13, 32'h1B, 32'h67, 32'h73, 32'h23, 32'h63, 32'h37, 32'h6F, 32'h33, 32'h7F, 32'h0B};
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_imm", out_imm, 64'd0);
    check("rst_fmt", 64'(out_fmt), 64'd0);
    check("rst_cnt", 64'(illegal_cnt), 64'd0);
    @(negedge clk);
    reset = 0;
    check("rst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      send(32'h0000007F, w);
      check("ill_flag", 64'(out_illegal), 64'd1);
      check("ill_cnt", 64'(illegal_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    drain();
    @(posedge clk);
    #2 reset = 1;
    q.delete();
    #1;
    check("arst_cnt", 64'(illegal_cnt), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 0;
    send(32'hFFF00093, w);
    check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_fmt", 64'(out_fmt), 64'd1);
    send(32'hFE000EE3, w);
    check("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("beq_fmt", 64'(out_fmt), 64'd3);
    send(32'h0010006F, w);
    check("jal_imm", out_imm, 64'h800);
    check("jal_fmt", 64'(out_fmt), 64'd5);
    send(32'h800000B7, w);
    check("lui_imm64", out_imm, 64'hFFFF_FFFF_8000_0000);
    check("lui_imm32", 64'(out_imm32), 64'h8000_0000);
    check("lui_fmt", 64'(out_fmt), 64'd4);
    drain();
    out_ready = 0;
    p0 = n_pop;
    send(32'h00500113, w);
    send(32'hABC00237, w);
    check("stall_ready", 64'(in_ready), 64'd0);
    in_valid = 1;
    in_instr = 32'h00C12023;
    @(negedge clk);
    check("stall_hold_imm", out_imm, 64'd5);
    out_ready = 1;
    send(32'h00C12023, w);
    drain();
    check("stall_count", 64'(n_pop - p0), 64'd3);
    out_ready = 0;
    send(32'h00100093, w);
    send(32'h00200093, w);
    flush = 1;
    in_valid = 1;
    in_instr = 32'h0000007F;
    @(posedge clk);
    #1;
    q.delete();
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    check("flush_cnt", 64'(illegal_cnt), 64'd0);
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    @(negedge clk);
    check("flush_noacc", 64'(out_valid), 64'd0);
    out_ready = 1;
    for (int i = 0; i < 24; i++) begin
      send({$urandom()} & 32'hFFFF_FF80 | ops[$urandom_range(0, 11)], w);
      check("tput_wait", 64'(w), 64'd0);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
